// File: rtl/controle_pkg.sv
// Shared definitions for the multicycle RV32-subset control unit: state codes,
// opcodes, ALU operation selects and the datapath strobe bundle.
package controle_pkg;

  // The state codes are visible on the estado bus and memoria depends on them.
  typedef enum logic [3:0] {
    S_FETCH  = 4'b0000,
    S_DECODE = 4'b0001,
    S_ADDR   = 4'b0010,
    S_MEMRD  = 4'b0011,
    S_WBLD   = 4'b0100,
    S_MEMWR  = 4'b0101,
    S_EXR    = 4'b0110,
    S_WBALU  = 4'b0111,
    S_BRANCH = 4'b1000,
    S_EXI    = 4'b1001,
    S_HALT   = 4'b1111
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       pcbranch;
    logic       alusrcb;
    logic [1:0] aluop;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       halted;
  } strobes_t;

  // Last state of every instruction; the edge leaving it retires the instruction.
  function automatic logic is_retire_state(input state_t s);
    return (s == S_WBLD) || (s == S_MEMWR) || (s == S_WBALU) || (s == S_BRANCH);
  endfunction

endpackage

// File: rtl/controle_decode.sv
// Moore output table: maps the registered state to datapath strobes.
// While hold is high every write/read/load strobe is suppressed.
module controle_decode
  import controle_pkg::*;
(
  input  state_t   state_i,
  input  logic     hold_i,
  input  logic     zero_i,
  output strobes_t strobes_o
);

  always_comb begin
    strobes_o       = '0;
    strobes_o.aluop = ALUOP_ADD;
    case (state_i)
      S_FETCH: begin
        strobes_o.irwrite = 1'b1;
        strobes_o.pcwrite = 1'b1;
      end
      S_ADDR:   strobes_o.alusrcb = 1'b1;
      S_MEMRD:  strobes_o.memread = 1'b1;
      S_MEMWR:  strobes_o.memwrite = 1'b1;
      S_WBLD: begin
        strobes_o.regwrite = 1'b1;
        strobes_o.memtoreg = 1'b1;
      end
      S_EXR:    strobes_o.aluop = ALUOP_FUNCT;
      S_EXI:    strobes_o.alusrcb = 1'b1;
      S_WBALU:  strobes_o.regwrite = 1'b1;
      S_BRANCH: begin
        strobes_o.aluop    = ALUOP_SUB;
        strobes_o.pcbranch = zero_i;
      end
      S_HALT:   strobes_o.halted = 1'b1;
      default:  strobes_o.halted = 1'b0;
    endcase

    // Select lines and halted stay visible during hold; only the side effects stop.
    if (hold_i) begin
      strobes_o.irwrite  = 1'b0;
      strobes_o.pcwrite  = 1'b0;
      strobes_o.pcbranch = 1'b0;
      strobes_o.memread  = 1'b0;
      strobes_o.memwrite = 1'b0;
      strobes_o.regwrite = 1'b0;
    end
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the RV32 subset datapath (R-type, addi, lw, sw, beq),
// with cycle and retired-instruction counters.
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic [6:0]       opcode,
  input  logic             zero,
  output logic [3:0]       estado,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             pcbranch,
  output logic             alusrcb,
  output logic [1:0]       aluop,
  output logic             memread,
  output logic             memwrite,
  output logic             regwrite,
  output logic             memtoreg,
  output logic             halted,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  strobes_t         strobes;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cycles_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cycles_q  <= cycles_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cycles_d  = cycles_q;
    retired_d = retired_q;
    if (!hold) begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_d = S_ADDR;
            OP_R:         state_d = S_EXR;
            OP_I:         state_d = S_EXI;
            OP_BEQ:       state_d = S_BRANCH;
            default:      state_d = S_HALT;
          endcase
        end
        // An opcode that is neither lw nor sw here means the IR was corrupted.
        S_ADDR:   state_d = (opcode == OP_LW) ? S_MEMRD :
                            (opcode == OP_SW) ? S_MEMWR : S_HALT;
        S_MEMRD:  state_d = S_WBLD;
        S_EXR:    state_d = S_WBALU;
        S_EXI:    state_d = S_WBALU;
        S_WBLD, S_MEMWR, S_WBALU, S_BRANCH: state_d = S_FETCH;
        S_HALT:   state_d = S_HALT;
        default:  state_d = S_HALT;
      endcase
      if (state_q != S_HALT) cycles_d = cycles_q + CNT_W'(1);
      if (is_retire_state(state_q)) retired_d = retired_q + CNT_W'(1);
    end
  end

  controle_decode u_decode (
    .state_i   (state_q),
    .hold_i    (hold),
    .zero_i    (zero),
    .strobes_o (strobes)
  );

  assign estado   = state_q;
  assign irwrite  = strobes.irwrite;
  assign pcwrite  = strobes.pcwrite;
  assign pcbranch = strobes.pcbranch;
  assign alusrcb  = strobes.alusrcb;
  assign aluop    = strobes.aluop;
  assign memread  = strobes.memread;
  assign memwrite = strobes.memwrite;
  assign regwrite = strobes.regwrite;
  assign memtoreg = strobes.memtoreg;
  assign halted   = strobes.halted;
  assign cycles   = cycles_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench: two instances (32-bit and 4-bit counters) share stimulus and are
// compared against an instruction-level reference model of paths and counters.
module tb_controle_multiciclo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hold = 1'b0;
  logic [6:0] opcode = 7'b0000011;
  logic       zero = 1'b0;

  logic [3:0]  estado_a, estado_b;
  logic        irw_a, pcw_a, pcb_a, asb_a, mr_a, mw_a, rw_a, mtr_a, hlt_a;
  logic        irw_b, pcw_b, pcb_b, asb_b, mr_b, mw_b, rw_b, mtr_b, hlt_b;
  logic [1:0]  aluop_a, aluop_b;
  logic [31:0] cyc_a, ret_a;
  logic [3:0]  cyc_b, ret_b;

  int compares = 0;
  int fails = 0;

  // Reference model: current state code, remaining path of the running instruction, counters.
  int          m_state = 0;
  int          m_q[$];
  int unsigned m_cycles = 0;
  int unsigned m_retired = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] AI = 7'b0010011, BQ = 7'b1100011, BAD = 7'b1111111;

  always #5 clk = ~clk;

  controle_multiciclo u_dut32 (
    .clk(clk), .reset(reset), .hold(hold), .opcode(opcode), .zero(zero),
    .estado(estado_a), .irwrite(irw_a), .pcwrite(pcw_a), .pcbranch(pcb_a),
    .alusrcb(asb_a), .aluop(aluop_a), .memread(mr_a), .memwrite(mw_a),
    .regwrite(rw_a), .memtoreg(mtr_a), .halted(hlt_a), .cycles(cyc_a), .retired(ret_a)
  );

  controle_multiciclo #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .hold(hold), .opcode(opcode), .zero(zero),
    .estado(estado_b), .irwrite(irw_b), .pcwrite(pcw_b), .pcbranch(pcb_b),
    .alusrcb(asb_b), .aluop(aluop_b), .memread(mr_b), .memwrite(mw_b),
    .regwrite(rw_b), .memtoreg(mtr_b), .halted(hlt_b), .cycles(cyc_b), .retired(ret_b)
  );

  // States visited after FETCH for each opcode (codes as seen on estado).
  function automatic void load_path(input logic [6:0] op);
    case (op)
      LW:      m_q = '{1, 2, 3, 4};
      SW:      m_q = '{1, 2, 5};
      RT:      m_q = '{1, 6, 7};
      AI:      m_q = '{1, 9, 7};
      BQ:      m_q = '{1, 8};
      default: m_q = '{1, 15};
    endcase
  endfunction

  function automatic logic [29:0] obs();
    return {estado_a, irw_a, pcw_a, pcb_a, asb_a, aluop_a, mr_a, mw_a, rw_a, mtr_a, hlt_a,
            estado_b, irw_b, pcw_b, pcb_b, asb_b, aluop_b, mr_b, mw_b, rw_b, mtr_b, hlt_b};
  endfunction

  function automatic logic [29:0] expv();
    logic ir, pc, pb, as, mr, mw, rw, mt, ht;
    logic [1:0] op;
    logic [14:0] v;
    {ir, pc, pb, as, mr, mw, rw, mt, ht} = '0;
    op = 2'b00;
    case (m_state)
      0:  begin ir = 1; pc = 1; end
      2:  as = 1;
      3:  mr = 1;
      4:  begin rw = 1; mt = 1; end
      5:  mw = 1;
      6:  op = 2'b10;
      7:  rw = 1;
      8:  begin op = 2'b01; pb = zero; end
      9:  as = 1;
      15: ht = 1;
      default: ht = 0;
    endcase
    if (hold) {ir, pc, pb, mr, mw, rw} = '0;
    v = {4'(m_state), ir, pc, pb, as, op, mr, mw, rw, mt, ht};
    return {v, v};
  endfunction

  function automatic logic [71:0] obs_cnt();
    return {cyc_a, ret_a, cyc_b, ret_b};
  endfunction

  function automatic logic [71:0] exp_cnt();
    return {m_cycles, m_retired, m_cycles[3:0], m_retired[3:0]};
  endfunction

  task automatic tick(input logic h, input logic r);
    hold = h;
    reset = r;
    @(posedge clk);
    if (r) begin
      m_state = 0; m_q.delete(); m_cycles = 0; m_retired = 0;
    end else if (!h && m_state != 15) begin
      m_cycles++;
      if (m_state == 0) begin
        load_path(opcode);
        m_state = m_q.pop_front();
      end else if (m_q.size() > 0) begin
        m_state = m_q.pop_front();
      end else begin
        m_state = 0;
        m_retired++;
      end
    end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick(0, 1);
    compares++;
    if (obs() !== expv()) begin
      fails++; $display("FAIL reset_out got %h want %h", obs(), expv());
    end
    compares++;
    if (obs_cnt() !== 72'd0) begin
      fails++; $display("FAIL reset_cnt got %h want 0", obs_cnt());
    end
    $display("reset: estado=%b irwrite=%b pcwrite=%b", estado_a, irw_a, pcw_a);
  endtask

  task automatic test_lw();
    tick(0, 1);
    opcode = LW;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0);
      compares++;
      if (obs() !== expv()) begin
        fails++; $display("FAIL lw_step%0d got %h want %h", i, obs(), expv());
      end
    end
    compares++;
    if (cyc_a !== 32'd5 || ret_a !== 32'd1 || estado_a !== 4'b0000) begin
      fails++; $display("FAIL lw_done got cyc=%0d ret=%0d st=%b want 5 1 0000", cyc_a, ret_a, estado_a);
    end
    $display("lw: cycles=%0d retired=%0d", cyc_a, ret_a);
  endtask

  task automatic test_sw();
    int mw_count = 0;
    int rw_seen = 0;
    tick(0, 1);
    opcode = SW;
    for (int i = 0; i < 4; i++) begin
      tick(0, 0);
      mw_count += mw_a;
      rw_seen += rw_a;
      compares++;
      if (obs() !== expv()) begin
        fails++; $display("FAIL sw_step%0d got %h want %h", i, obs(), expv());
      end
    end
    compares++;
    if (mw_count != 1 || rw_seen != 0 || ret_a !== 32'd1 || estado_a !== 4'b0000) begin
      fails++; $display("FAIL sw_done got mw=%0d rw=%0d ret=%0d st=%b want 1 0 1 0000",
                        mw_count, rw_seen, ret_a, estado_a);
    end
    $display("sw: memwrite cycles=%0d retired=%0d", mw_count, ret_a);
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      tick(0, 1);
      opcode = BQ;
      zero = z[0];
      tick(0, 0);
      tick(0, 0);
      compares++;
      if (estado_a !== 4'b1000 || pcb_a !== z[0] || aluop_a !== 2'b01) begin
        fails++; $display("FAIL beq_z%0d got st=%b pcb=%b want 1000 %0d", z, estado_a, pcb_a, z);
      end
      tick(0, 0);
      compares++;
      if (obs() !== expv() || estado_a !== 4'b0000 || ret_a !== 32'd1) begin
        fails++; $display("FAIL beq_ret_z%0d got st=%b ret=%0d want 0000 1", z, estado_a, ret_a);
      end
      $display("beq zero=%0d: back to estado=%b", z, estado_a);
    end
  endtask

  task automatic test_halt();
    tick(0, 1);
    opcode = BAD;
    tick(0, 0);
    tick(0, 0);
    compares++;
    if (estado_a !== 4'b1111 || hlt_a !== 1'b1 || cyc_a !== 32'd2) begin
      fails++; $display("FAIL halt_enter got st=%b halted=%b cyc=%0d want 1111 1 2", estado_a, hlt_a, cyc_a);
    end
    for (int i = 0; i < 10; i++) begin
      tick(0, 0);
      compares++;
      if (obs() !== expv() || obs_cnt() !== exp_cnt()) begin
        fails++; $display("FAIL halt_hold%0d got %h/%h want %h/%h", i, obs(), obs_cnt(), expv(), exp_cnt());
      end
    end
    tick(0, 1);
    compares++;
    if (estado_a !== 4'b0000 || hlt_a !== 1'b0 || obs_cnt() !== 72'd0) begin
      fails++; $display("FAIL halt_reset got st=%b cnt=%h want 0000 0", estado_a, obs_cnt());
    end
    $display("halt: entered, frozen 10 cycles, reset to estado=%b", estado_a);
  endtask

  task automatic test_hold();
    tick(0, 1);
    opcode = LW;
    for (int i = 0; i < 3; i++) tick(0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0);
      compares++;
      if (estado_a !== 4'b0011 || mr_a !== 1'b0 || cyc_a !== 32'd3 || obs() !== expv()) begin
        fails++; $display("FAIL hold%0d got st=%b memread=%b cyc=%0d want 0011 0 3", i, estado_a, mr_a, cyc_a);
      end
    end
    hold = 1'b0;
    #1;
    compares++;
    if (mr_a !== 1'b1) begin
      fails++; $display("FAIL hold_release_memread got %b want 1", mr_a);
    end
    tick(0, 0);
    compares++;
    if (estado_a !== 4'b0100 || cyc_a !== 32'd4 || obs() !== expv()) begin
      fails++; $display("FAIL hold_release got st=%b cyc=%0d want 0100 4", estado_a, cyc_a);
    end
    $display("hold: held in MEMRD, released to estado=%b", estado_a);
  endtask

  task automatic test_wrap();
    tick(0, 1);
    opcode = AI;
    for (int i = 0; i < 16; i++) tick(0, 0);
    compares++;
    if (cyc_b !== 4'd0 || ret_b !== 4'd4 || cyc_a !== 32'd16 || ret_a !== 32'd4) begin
      fails++; $display("FAIL wrap got cyc4=%0d ret4=%0d cyc32=%0d want 0 4 16", cyc_b, ret_b, cyc_a);
    end
    $display("wrap: cycles4=%0d retired4=%0d cycles32=%0d", cyc_b, ret_b, cyc_a);
  endtask

  task automatic test_random();
    logic [6:0] ops[5];
    int r;
    ops = '{LW, SW, RT, AI, BQ};
    tick(0, 1);
    for (int i = 0; i < 400; i++) begin
      if (m_state == 0) begin
        r = $urandom_range(0, 39);
        opcode = (r < 39) ? ops[r % 5] : BAD;
      end
      zero = 1'($urandom_range(0, 1));
      tick(($urandom_range(0, 4) == 0), ($urandom_range(0, 59) == 0) || (m_state == 15 && $urandom_range(0, 3) == 0));
      compares++;
      if (obs() !== expv() || obs_cnt() !== exp_cnt()) begin
        fails++; $display("FAIL rand%0d got %h/%h want %h/%h", i, obs(), obs_cnt(), expv(), exp_cnt());
      end
    end
    $display("random: cycles=%0d retired=%0d", cyc_a, ret_a);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_halt();
    test_hold();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
